// File: rtl/ofifo_collect_if.sv
// rtl/ofifo_collect_if.sv - row/column handshake bundle for the output collector
// Purpose: groups the column write bus, the row read request and the row
//          output/status signals of ofifo_collect.
// Signals:
//   in       column psums, column c at [psum_bw*(c+1)-1:psum_bw*c]
//   wr       per-column write strobes
//   rd       row read request
//   o_full   any column FIFO full
//   o_ready  all columns can take a word
//   o_valid  every column non-empty, a row can be read
//   out      registered row data
//   out_vld  out holds the row popped on the previous cycle
//   overflow sticky dropped-write flag
// Modports: master drives in/wr/rd; slave (the collector) drives the rest.
interface ofifo_collect_if #(
    parameter int col     = 4,
    parameter int psum_bw = 16
);
    logic [psum_bw*col-1:0] in;
    logic [col-1:0]         wr;
    logic                   rd;
    logic                   o_full;
    logic                   o_ready;
    logic                   o_valid;
    logic [psum_bw*col-1:0] out;
    logic                   out_vld;
    logic                   overflow;

    modport master (
        output in, wr, rd,
        input  o_full, o_ready, o_valid, out, out_vld, overflow
    );

    modport slave (
        input  in, wr, rd,
        output o_full, o_ready, o_valid, out, out_vld, overflow
    );
endinterface

// File: rtl/ofifo_collect.sv
// rtl/ofifo_collect.sv - per-column psum FIFOs released as aligned rows
// Purpose: each MAC column pushes psums into its own circular FIFO on its
//          own (skewed) strobe; a row read pops the head of every column
//          together and registers it onto out with a one-cycle valid pulse.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    ofifo_collect_if.slave (in/wr/rd in; flags, out, out_vld, overflow out)
module ofifo_collect #(
    parameter int col     = 4,
    parameter int psum_bw = 16,
    parameter int depth   = 8
) (
    input  logic           clk,
    input  logic           reset,
    ofifo_collect_if.slave bus
);
    localparam int AW = $clog2(depth);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PONE = PW'(1);

    logic [col-1:0]         empty_c;
    logic [col-1:0]         full_c;
    logic [col-1:0]         wr_fire;
    logic [psum_bw*col-1:0] heads;
    logic                   o_valid;
    logic                   rd_fire;

    logic [psum_bw*col-1:0] out_q, out_d;
    logic                   out_vld_q, out_vld_d;
    logic                   overflow_q, overflow_d;

    // Flags come only from registered pointers so a write never becomes
    // readable in the same cycle it arrives.
    assign o_valid = &(~empty_c);
    assign rd_fire = bus.rd & o_valid;

    for (genvar c = 0; c < col; c++) begin : g_col
        logic [psum_bw-1:0] mem_q [depth];
        logic [PW-1:0]      wptr_q, wptr_d;
        logic [PW-1:0]      rptr_q, rptr_d;

        assign empty_c[c] = (wptr_q == rptr_q);
        assign full_c[c]  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) &&
                            (wptr_q[AW] != rptr_q[AW]);
        // A full column still accepts a write when the row pop frees its head
        // slot in the same cycle; the pop reads the old head before the write.
        assign wr_fire[c] = bus.wr[c] & (~full_c[c] | rd_fire);
        assign heads[c*psum_bw +: psum_bw] = mem_q[rptr_q[AW-1:0]];

        always_comb begin
            wptr_d = wptr_q;
            rptr_d = rptr_q;
            if (wr_fire[c]) wptr_d = wptr_q + PONE;
            if (rd_fire)    rptr_d = rptr_q + PONE;
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                wptr_q <= '0;
                rptr_q <= '0;
            end else begin
                wptr_q <= wptr_d;
                rptr_q <= rptr_d;
            end
        end

        always_ff @(posedge clk) begin
            if (wr_fire[c]) mem_q[wptr_q[AW-1:0]] <= bus.in[c*psum_bw +: psum_bw];
        end
    end

    always_comb begin
        out_d      = out_q;
        out_vld_d  = rd_fire;
        overflow_d = overflow_q;
        if (rd_fire) out_d = heads;
        if (|(bus.wr & full_c & ~{col{rd_fire}})) overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q      <= '0;
            out_vld_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            out_q      <= out_d;
            out_vld_q  <= out_vld_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.o_full   = |full_c;
    assign bus.o_ready  = ~(|full_c);
    assign bus.o_valid  = o_valid;
    assign bus.out      = out_q;
    assign bus.out_vld  = out_vld_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_ofifo_collect.sv
// tb/tb_ofifo_collect.sv - scoreboard bench for ofifo_collect
module tb_ofifo_collect;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    ofifo_collect_if #(.col(4), .psum_bw(16)) dut_if ();

    ofifo_collect #(.col(4), .psum_bw(16), .depth(8)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dut_if.slave)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] mkrow(input logic [11:0] k);
        logic [63:0] r;
        for (int c = 0; c < 4; c++) r[c*16 +: 16] = {k, 4'(c)};
        return r;
    endfunction

    // Monitor: every out_vld pulse must match the oldest expected row.
    always @(negedge clk) begin
        if (reset && dut_if.out_vld) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_row: got %h expected no row", dut_if.out);
            end else begin
                chk("row", dut_if.out, sb.pop_front());
            end
        end
    end

    initial begin
        // 1: reset with random traffic
        reset     = 1'b0;
        dut_if.in = '0;
        dut_if.wr = '0;
        dut_if.rd = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dut_if.in = {$urandom, $urandom};
            dut_if.wr = 4'($urandom);
            dut_if.rd = 1'($urandom);
            tick();
        end
        chk("rst_o_valid", 64'(dut_if.o_valid), 64'd0);
        chk("rst_o_ready", 64'(dut_if.o_ready), 64'd1);
        chk("rst_o_full", 64'(dut_if.o_full), 64'd0);
        chk("rst_out", dut_if.out, 64'd0);
        chk("rst_out_vld", 64'(dut_if.out_vld), 64'd0);
        chk("rst_overflow", 64'(dut_if.overflow), 64'd0);
        dut_if.in = '0;
        dut_if.wr = '0;
        dut_if.rd = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // 2: skewed column writes
        for (int c = 0; c < 4; c++) begin
            dut_if.in[c*16 +: 16] = 16'h0010 + 16'(c);
            dut_if.wr = 4'(1 << c);
            tick();
            if (c == 2) chk("skew_not_valid", 64'(dut_if.o_valid), 64'd0);
        end
        dut_if.wr = '0;
        chk("skew_valid", 64'(dut_if.o_valid), 64'd1);
        dut_if.rd = 1'b1;
        sb.push_back(64'h0013_0012_0011_0010);
        tick();
        dut_if.rd = 1'b0;
        chk("skew_empty_after", 64'(dut_if.o_valid), 64'd0);

        // 3: fill, partial drain, wrap
        dut_if.wr = 4'hF;
        for (int k = 1; k <= 8; k++) begin
            dut_if.in = mkrow(12'(k));
            tick();
        end
        dut_if.wr = '0;
        chk("fill_full", 64'(dut_if.o_full), 64'd1);
        chk("fill_ready", 64'(dut_if.o_ready), 64'd0);
        dut_if.rd = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            sb.push_back(mkrow(12'(k)));
            tick();
        end
        dut_if.rd = 1'b0;
        chk("partial_not_full", 64'(dut_if.o_full), 64'd0);
        dut_if.wr = 4'hF;
        for (int k = 9; k <= 11; k++) begin
            dut_if.in = mkrow(12'(k));
            tick();
        end
        dut_if.wr = '0;
        chk("wrap_full", 64'(dut_if.o_full), 64'd1);
        dut_if.rd = 1'b1;
        for (int k = 4; k <= 11; k++) begin
            sb.push_back(mkrow(12'(k)));
            tick();
        end
        dut_if.rd = 1'b0;
        chk("drain_empty", 64'(dut_if.o_valid), 64'd0);

        // 4: write into full columns while popping a row
        dut_if.wr = 4'hF;
        for (int k = 12; k <= 19; k++) begin
            dut_if.in = mkrow(12'(k));
            tick();
        end
        chk("simul_full_before", 64'(dut_if.o_full), 64'd1);
        dut_if.in = mkrow(12'd20);
        dut_if.rd = 1'b1;
        sb.push_back(mkrow(12'd12));
        tick();
        dut_if.wr = '0;
        dut_if.rd = 1'b0;
        chk("simul_overflow", 64'(dut_if.overflow), 64'd0);
        chk("simul_still_full", 64'(dut_if.o_full), 64'd1);
        dut_if.rd = 1'b1;
        for (int k = 13; k <= 20; k++) begin
            sb.push_back(mkrow(12'(k)));
            tick();
        end
        dut_if.rd = 1'b0;
        chk("simul_drained", 64'(dut_if.o_valid), 64'd0);

        // 5: overflow on column 2
        dut_if.wr = 4'b0100;
        for (int k = 0; k < 8; k++) begin
            dut_if.in = mkrow(12'h030 + 12'(k));
            tick();
        end
        chk("ovf_col2_full", 64'(dut_if.o_full), 64'd1);
        chk("ovf_not_valid", 64'(dut_if.o_valid), 64'd0);
        dut_if.in = {4{16'hEEEE}};
        tick();
        dut_if.wr = '0;
        chk("ovf_set", 64'(dut_if.overflow), 64'd1);
        dut_if.wr = 4'b1011;
        for (int k = 0; k < 8; k++) begin
            dut_if.in = mkrow(12'h030 + 12'(k));
            tick();
        end
        dut_if.wr = '0;
        dut_if.rd = 1'b1;
        for (int k = 0; k < 8; k++) begin
            sb.push_back(mkrow(12'h030 + 12'(k)));
            tick();
        end
        dut_if.rd = 1'b0;
        chk("ovf_sticky", 64'(dut_if.overflow), 64'd1);
        chk("ovf_drained", 64'(dut_if.o_valid), 64'd0);

        // 6: read while column 1 empty, then mid-operation reset
        dut_if.wr = 4'b1101;
        dut_if.in = mkrow(12'h050);
        tick();
        dut_if.wr = '0;
        chk("col1_empty_not_valid", 64'(dut_if.o_valid), 64'd0);
        dut_if.rd = 1'b1;
        tick();
        dut_if.rd = 1'b0;
        chk("empty_rd_no_vld", 64'(dut_if.out_vld), 64'd0);
        dut_if.wr = 4'b0010;
        tick();
        dut_if.wr = '0;
        chk("col1_filled_valid", 64'(dut_if.o_valid), 64'd1);
        dut_if.rd = 1'b1;
        sb.push_back(mkrow(12'h050));
        tick();
        dut_if.rd = 1'b0;
        dut_if.wr = 4'hF;
        for (int k = 0; k < 5; k++) begin
            dut_if.in = mkrow(12'h060 + 12'(k));
            tick();
        end
        dut_if.wr = '0;
        chk("queued_valid", 64'(dut_if.o_valid), 64'd1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_o_valid", 64'(dut_if.o_valid), 64'd0);
        chk("midrst_o_ready", 64'(dut_if.o_ready), 64'd1);
        chk("midrst_overflow", 64'(dut_if.overflow), 64'd0);
        chk("midrst_out", dut_if.out, 64'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("post_rst_empty", 64'(dut_if.o_valid), 64'd0);
        tick();
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
